// File: rtl/brianhg_ddr3_pll.sv
// brianhg_ddr3_pll: oversampled DDR3 clock generator.
// CLK_IN runs at 8x DDR3_CLK; a free-running 5-bit counter drives every
// generated clock, each phase picked as a 3-bit slot offset.
// Optional macro BRIANHG_PLL_PHASE_STEP_EN adds runtime stepping of the
// write-DQ clock phase; without it the step inputs are ignored.
module brianhg_ddr3_pll #(
  parameter int    CLK_KHZ_IN         = 50000,
  parameter int    CLK_IN_MULT        = 32,
  parameter int    CLK_IN_DIV         = 4,
  parameter string INTERFACE_SPEED    = "Full",
  parameter int    DDR3_WDQ_PHASE     = 270,
  parameter int    DDR3_RDQ_PHASE     = 0,
  parameter int    LOCK_CYCLES        = 256,
  parameter string FPGA_VENDOR        = "Altera",
  parameter string FPGA_FAMILY        = "Cyclone V",
  parameter int    DDR_TRICK_MTPS_CAP = 0
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  output logic DDR3_CLK,
  output logic DDR3_CLK_WDQ,
  output logic DDR3_CLK_RDQ,
  output logic DDR3_CLK_50,
  output logic DDR3_CLK_25,
  output logic CMD_CLK,
  output logic PLL_LOCKED,
  output logic RST_OUT,
  input  logic phase_step,
  input  logic phase_updn,
  input  logic phase_sclk,
  output logic phase_done
);

  // 0=Full, 1=Half, 2=Quarter, 3=illegal
  localparam int SPEED = (INTERFACE_SPEED == "Full")    ? 0 :
                         (INTERFACE_SPEED == "Half")    ? 1 :
                         (INTERFACE_SPEED == "Quarter") ? 2 : 3;

  localparam logic [2:0] K_WDQ = 3'(DDR3_WDQ_PHASE / 45);
  localparam logic [2:0] K_RDQ = 3'(DDR3_RDQ_PHASE / 45);

  generate
    if (SPEED == 3) begin : g_bad_speed
      $error("INTERFACE_SPEED must be Full, Half or Quarter");
    end
    if ((DDR3_WDQ_PHASE % 45) != 0 || DDR3_WDQ_PHASE < 0 || DDR3_WDQ_PHASE > 315) begin : g_bad_wdq
      $error("DDR3_WDQ_PHASE must be a multiple of 45 in 0..315");
    end
    if ((DDR3_RDQ_PHASE % 45) != 0 || DDR3_RDQ_PHASE < 0 || DDR3_RDQ_PHASE > 315) begin : g_bad_rdq
      $error("DDR3_RDQ_PHASE must be a multiple of 45 in 0..315");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("LOCK_CYCLES must be in 1..65535");
    end
  endgenerate

  // High for the 4 slots starting at slot k (50% duty, 8-slot period).
  function automatic logic phase_hi(input logic [2:0] s, input logic [2:0] k);
    logic [2:0] d;
    d = s - k;
    return ~d[2];
  endfunction

  logic [4:0]  c;
  logic [15:0] lock_cnt;
  logic [2:0]  off;
  logic [2:0]  k_wdq;

  assign k_wdq = K_WDQ + off;

`ifdef BRIANHG_PLL_PHASE_STEP_EN
  logic       step_r, step_q;
  logic [3:0] busy_pipe;  // one bit per busy cycle, drains toward bit 0
  logic       step_req;
  logic       unused_ok;

  assign step_req   = step_r & ~step_q & PLL_LOCKED & phase_done;
  assign phase_done = ~|busy_pipe;
  assign unused_ok  = ^{phase_sclk, CLK_KHZ_IN != 0, CLK_IN_MULT != 0, CLK_IN_DIV != 0,
                        FPGA_VENDOR == "", FPGA_FAMILY == "", DDR_TRICK_MTPS_CAP != 0};

  // Step request edge detect, offset update and busy window.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      step_r    <= 1'b0;
      step_q    <= 1'b0;
      busy_pipe <= '0;
      off       <= '0;
    end else begin
      step_r <= phase_step;
      step_q <= step_r;
      if (step_req) begin
        busy_pipe <= '1;
        off       <= phase_updn ? off + 3'd1 : off - 3'd1;
      end else begin
        busy_pipe <= busy_pipe >> 1;
      end
    end
  end
`else
  logic unused_ok;

  assign off        = '0;
  assign phase_done = 1'b1;
  assign unused_ok  = ^{phase_step, phase_updn, phase_sclk, CLK_KHZ_IN != 0, CLK_IN_MULT != 0,
                        CLK_IN_DIV != 0, FPGA_VENDOR == "", FPGA_FAMILY == "",
                        DDR_TRICK_MTPS_CAP != 0};
`endif

  // Slot counter and registered clock outputs (each reflects last cycle's c).
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      c            <= '0;
      DDR3_CLK     <= 1'b0;
      DDR3_CLK_WDQ <= 1'b0;
      DDR3_CLK_RDQ <= 1'b0;
      DDR3_CLK_50  <= 1'b0;
      DDR3_CLK_25  <= 1'b0;
    end else begin
      c            <= c + 5'd1;
      DDR3_CLK     <= phase_hi(c[2:0], 3'd0);
      DDR3_CLK_WDQ <= phase_hi(c[2:0], k_wdq);
      DDR3_CLK_RDQ <= phase_hi(c[2:0], K_RDQ);
      DDR3_CLK_50  <= ~c[3];
      DDR3_CLK_25  <= ~c[4];
    end
  end

  // Lock timer: lock sticks once the count hits LOCK_CYCLES.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      lock_cnt   <= '0;
      PLL_LOCKED <= 1'b0;
      RST_OUT    <= 1'b1;
    end else if (!PLL_LOCKED) begin
      lock_cnt <= lock_cnt + 16'd1;
      if (lock_cnt + 16'd1 == 16'(LOCK_CYCLES)) begin
        PLL_LOCKED <= 1'b1;
        RST_OUT    <= 1'b0;
      end
    end
  end

  generate
    if (SPEED == 1) begin : g_half
      assign CMD_CLK = DDR3_CLK_50;
    end else if (SPEED == 2) begin : g_quarter
      assign CMD_CLK = DDR3_CLK_25;
    end else begin : g_full
      assign CMD_CLK = DDR3_CLK;
    end
  endgenerate

endmodule

// File: tb/tb_brianhg_ddr3_pll.sv
// Directed bench for brianhg_ddr3_pll: reset, lock timing, clock waveforms,
// Half-rate CMD_CLK and (macro-dependent) write-phase stepping.
module tb_brianhg_ddr3_pll;

  logic clk, rst_n, step, updn, sclk;
  logic d_clk, d_wdq, d_rdq, d_c50, d_c25, d_cmd, d_lock, d_rsto, d_done;
  logic h_clk, h_wdq, h_rdq, h_c50, h_c25, h_cmd, h_lock, h_rsto, h_done;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  logic [7:0] ddr_pat = 8'b0000_1111;  // bit s = DDR3_CLK at slot s
  logic [7:0] wdq_pat = 8'b1100_0011;  // k=6: high in slots 6,7,0,1

  brianhg_ddr3_pll u0 (
    .CLK_IN(clk), .RST_IN(rst_n),
    .DDR3_CLK(d_clk), .DDR3_CLK_WDQ(d_wdq), .DDR3_CLK_RDQ(d_rdq),
    .DDR3_CLK_50(d_c50), .DDR3_CLK_25(d_c25), .CMD_CLK(d_cmd),
    .PLL_LOCKED(d_lock), .RST_OUT(d_rsto),
    .phase_step(step), .phase_updn(updn), .phase_sclk(sclk), .phase_done(d_done)
  );

  brianhg_ddr3_pll #(.INTERFACE_SPEED("Half")) u1 (
    .CLK_IN(clk), .RST_IN(rst_n),
    .DDR3_CLK(h_clk), .DDR3_CLK_WDQ(h_wdq), .DDR3_CLK_RDQ(h_rdq),
    .DDR3_CLK_50(h_c50), .DDR3_CLK_25(h_c25), .CMD_CLK(h_cmd),
    .PLL_LOCKED(h_lock), .RST_OUT(h_rsto),
    .phase_step(step), .phase_updn(updn), .phase_sclk(sclk), .phase_done(h_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then park on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  // cycles from a DDR3_CLK rise to the next DDR3_CLK_WDQ rise; negative on timeout
  task automatic measure_lag(output int lag);
    logic pd, pw;
    bit   found;
    lag   = -2;
    found = 0;
    pd = d_clk;
    pw = d_wdq;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (d_clk && !pd) found = 1;
      else begin
        pd = d_clk;
        pw = d_wdq;
      end
    end
    if (found) begin
      lag = -1;
      for (int m = 0; m < 16; m++) begin
        if (d_wdq && !pw) begin
          lag = m;
          break;
        end
        pw = d_wdq;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step  = 1'b0;
    updn  = 1'b0;
    sclk  = 1'b0;
    repeat (10) tick();
    checks++;
    if ({d_clk, d_wdq, d_rdq, d_c50, d_c25, d_cmd} !== 6'b0) begin
      errors++;
      $display("FAIL reset_clocks got %b want 000000", {d_clk, d_wdq, d_rdq, d_c50, d_c25, d_cmd});
    end
    checks++;
    if (d_rsto !== 1'b1 || d_lock !== 1'b0) begin
      errors++;
      $display("FAIL reset_lock got rst_out=%b locked=%b want 1/0", d_rsto, d_lock);
    end
    checks++;
    if (d_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_done got %b want 1", d_done);
    end
    checks++;
    if (h_cmd !== 1'b0) begin
      errors++;
      $display("FAIL reset_half_cmd got %b want 0", h_cmd);
    end
  endtask

  // release reset, wait out the lock count; also fires a step before lock
  task automatic test_lock(input bit pre_lock_step);
    edges = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (pre_lock_step && n == 40) begin
        updn = 1'b1;
        step = 1'b1;
      end
      if (n == 44) step = 1'b0;
      checks++;
      if (n < 256 && (d_lock !== 1'b0 || d_rsto !== 1'b1)) begin
        errors++;
        $display("FAIL lock_early n=%0d got locked=%b rst_out=%b want 0/1", n, d_lock, d_rsto);
      end else if (n == 256 && (d_lock !== 1'b1 || d_rsto !== 1'b0)) begin
        errors++;
        $display("FAIL lock_at_256 got locked=%b rst_out=%b want 1/0", d_lock, d_rsto);
      end
      checks++;
      if (d_done !== 1'b1) begin
        errors++;
        $display("FAIL prelock_done n=%0d got %b want 1", n, d_done);
      end
    end
  endtask

  task automatic test_clocks();
    logic [4:0] cv;
    logic [2:0] s;
    logic       e_clk, e_wdq, e_50, e_25;
    int         lag;
    for (int i = 0; i < 32; i++) begin
      tick();
      cv    = 5'((edges - 1) % 32);
      s     = cv[2:0];
      e_clk = ddr_pat[s];
      e_wdq = wdq_pat[s];
      e_50  = ~cv[3];
      e_25  = ~cv[4];
      checks++;
      if ({d_clk, d_rdq, d_cmd, d_wdq, d_c50, d_c25} !== {e_clk, e_clk, e_clk, e_wdq, e_50, e_25}) begin
        errors++;
        $display("FAIL waves c=%0d got clk/rdq/cmd/wdq/50/25=%b want %b", cv,
                 {d_clk, d_rdq, d_cmd, d_wdq, d_c50, d_c25}, {e_clk, e_clk, e_clk, e_wdq, e_50, e_25});
      end
      checks++;
      if (h_cmd !== e_50) begin
        errors++;
        $display("FAIL half_cmd c=%0d got %b want %b", cv, h_cmd, e_50);
      end
    end
    measure_lag(lag);
    checks++;
    if (lag != 6) begin
      errors++;
      $display("FAIL wdq_lag_default got %0d want 6", lag);
    end
  endtask

  task automatic test_step_up();
    int lows, lag, exp_lag, exp_low;
    updn = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef BRIANHG_PLL_PHASE_STEP_EN
      exp_lag = (i == 0) ? 7 : (i == 1) ? 0 : 1;
      exp_low = 4;
`else
      exp_lag = 6;
      exp_low = 0;
`endif
      lows = 0;
      step = 1'b1;
      for (int t = 0; t < 14; t++) begin
        tick();
        if (t == 1) step = 1'b0;
        if (!d_done) lows++;
      end
      checks++;
      if (lows != exp_low) begin
        errors++;
        $display("FAIL step_up_busy%0d got %0d low cycles want %0d", i, lows, exp_low);
      end
      measure_lag(lag);
      checks++;
      if (lag != exp_lag) begin
        errors++;
        $display("FAIL step_up_lag%0d got %0d want %0d", i, lag, exp_lag);
      end
    end
  endtask

  task automatic test_mid_step_reset();
    int lag;
    updn = 1'b1;
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (d_done !== 1'b1 || d_wdq !== 1'b0 || d_lock !== 1'b0) begin
      errors++;
      $display("FAIL midstep_reset got done=%b wdq=%b locked=%b want 1/0/0", d_done, d_wdq, d_lock);
    end
    repeat (3) tick();
    test_lock(1'b0);
    measure_lag(lag);
    checks++;
    if (lag != 6) begin
      errors++;
      $display("FAIL midstep_off_cleared got lag %0d want 6", lag);
    end
  endtask

  task automatic test_step_down();
    int lows, lag, exp_lag, exp_low;
`ifdef BRIANHG_PLL_PHASE_STEP_EN
    exp_lag = 5;
    exp_low = 4;
`else
    exp_lag = 6;
    exp_low = 0;
`endif
    updn = 1'b0;
    lows = 0;
    step = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (t == 1) step = 1'b0;
      if (t == 2) step = 1'b1;  // second request lands inside the busy window
      if (t == 3) step = 1'b0;
      if (!d_done) lows++;
    end
    checks++;
    if (lows != exp_low) begin
      errors++;
      $display("FAIL step_down_busy got %0d low cycles want %0d", lows, exp_low);
    end
    measure_lag(lag);
    checks++;
    if (lag != exp_lag) begin
      errors++;
      $display("FAIL step_down_lag got %0d want %0d", lag, exp_lag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step  = 1'b0;
    updn  = 1'b0;
    sclk  = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock(1'b1);
    test_clocks();
    test_step_up();
    test_mid_step_reset();
    test_step_down();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
